// File: rtl/phase_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : phase_seq_gen
//  Description : Machine-cycle phase sequencer. Produces a one-hot train of
//                NUM_PHASES phase enables, either free-running (run_i) or as
//                a single cycle on request (step_i). One phase (WAIT_PHASE)
//                can be stretched by wait_i. Completed cycles are counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_seq_gen #(
  parameter int NUM_PHASES = 3,
  parameter int WAIT_PHASE = 0,
  parameter int CNT_W      = 32,
  localparam int IDX_W     = ($clog2(NUM_PHASES) > 1) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run_i,
  input  logic                  step_i,
  input  logic                  wait_i,
  output logic [NUM_PHASES-1:0] phase_o,
  output logic [IDX_W-1:0]      phase_idx_o,
  output logic                  cycle_done_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      cycle_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] c_WAIT_IDX = IDX_W'(WAIT_PHASE);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_PHASES - 1);

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_PHASES-1:0]   r_phase;
  logic                    r_done;
  logic                    r_busy;

  state_t                  w_state_nxt;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [NUM_PHASES-1:0]   w_phase_nxt;
  logic                    w_done_nxt;
  logic                    w_busy_nxt;
  logic                    w_stall;

  // The stretchable phase freezes everything, including the end-of-cycle
  // transition when the stretchable phase is also the last one.
  assign w_stall = (r_idx == c_WAIT_IDX) && wait_i;

  // Next-state, next-index and counter logic; output images follow directly
  // from the next state so every output is a plain register.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = '0;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (run_i) begin
          w_state_nxt = S_RUN;
        end else if (step_i) begin
          w_state_nxt = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        // step_i is deliberately not looked at here: no request is queued.
        if (!w_stall) begin
          if (r_idx == c_LAST_IDX) begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_idx_nxt   = '0;
            w_state_nxt = run_i ? S_RUN : S_IDLE;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    if (w_busy_nxt) begin
      w_phase_nxt[w_idx_nxt] = 1'b1;
      w_done_nxt             = (w_idx_nxt == c_LAST_IDX);
    end
  end

  // State and output registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign phase_o      = r_phase;
  assign phase_idx_o  = r_idx;
  assign cycle_done_o = r_done;
  assign busy_o       = r_busy;
  assign cycle_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_phase_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phase_seq_gen
//  Description : Self-checking bench for phase_seq_gen. Two instances share
//                the stimulus: a 3-phase / wait-phase-0 / 32-bit counter one
//                and a 5-phase / wait-phase-4 / 4-bit counter one. A cycle
//                level reference model predicts both.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_seq_gen;

  logic clk;
  logic rst_n;
  logic run_i;
  logic step_i;
  logic wait_i;

  logic [2:0]  ph0;
  logic [1:0]  ix0;
  logic        dn0;
  logic        bz0;
  logic [31:0] ct0;

  logic [4:0]  ph1;
  logic [2:0]  ix1;
  logic        dn1;
  logic        bz1;
  logic [3:0]  ct1;

  int n_tests = 0;
  int n_fail  = 0;

  phase_seq_gen #(.NUM_PHASES(3), .WAIT_PHASE(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_i(step_i), .wait_i(wait_i),
    .phase_o(ph0), .phase_idx_o(ix0), .cycle_done_o(dn0), .busy_o(bz0),
    .cycle_cnt_o(ct0)
  );

  phase_seq_gen #(.NUM_PHASES(5), .WAIT_PHASE(4), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_i(step_i), .wait_i(wait_i),
    .phase_o(ph1), .phase_idx_o(ix1), .cycle_done_o(dn1), .busy_o(bz1),
    .cycle_cnt_o(ct1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a machine is either idle or sitting on a phase number.
  // RUN and STEP differ only in why the cycle started, which never changes
  // what is observed, so the model does not track it.
  int          MN[2] = '{3, 5};
  int          MW[2] = '{0, 4};
  int          MC[2] = '{32, 4};
  bit          m_busy[2];
  int          m_idx[2];
  longint      m_cnt[2];
  logic [31:0] e_ph[2];
  logic [31:0] e_idx[2];
  logic [31:0] e_cnt[2];
  logic        e_done[2];
  logic        e_busy[2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0;
      m_idx[k]  = 0;
      m_cnt[k]  = 0;
    end
  endtask

  task automatic model_expect();
    for (int k = 0; k < 2; k++) begin
      e_ph[k]   = m_busy[k] ? (32'd1 << m_idx[k]) : 32'd0;
      e_idx[k]  = m_busy[k] ? 32'(m_idx[k]) : 32'd0;
      e_done[k] = m_busy[k] && (m_idx[k] == MN[k] - 1);
      e_busy[k] = m_busy[k];
      e_cnt[k]  = 32'(m_cnt[k]);
    end
  endtask

  // One rising edge: the model consumes the inputs present at the edge, the
  // outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 1'b0;
        m_idx[k]  = 0;
        m_cnt[k]  = 0;
      end else if (!m_busy[k]) begin
        if (run_i || step_i) begin
          m_busy[k] = 1'b1;
          m_idx[k]  = 0;
        end
      end else if (m_idx[k] == MW[k] && wait_i) begin
        m_idx[k] = m_idx[k];
      end else if (m_idx[k] == MN[k] - 1) begin
        m_cnt[k] = (m_cnt[k] + 1) % (longint'(1) << MC[k]);
        m_idx[k] = 0;
        if (!run_i) m_busy[k] = 1'b0;
      end else begin
        m_idx[k] = m_idx[k] + 1;
      end
    end
    model_expect();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_i = 1'b1; step_i = 1'b1; wait_i = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({ph0, ix0, dn0, bz0, ct0} !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_dut0: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want all zero", ph0, ix0, dn0, bz0, ct0);
    end
    n_tests++;
    if ({ph1, ix1, dn1, bz1, ct1} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_dut1: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want all zero", ph1, ix1, dn1, bz1, ct1);
    end
    run_i = 1'b0; step_i = 1'b0;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({ph0, ix0, dn0, bz0, ct0} !== 39'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got ph=%b idx=%0d busy=%b cnt=%0d, want all zero", ph0, ix0, bz0, ct0);
    end
  endtask

  task automatic test_free_run();
    logic [2:0] want;
    run_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      want = 3'b001 << (i % 3);
      n_tests++;
      if ({ph0, ix0, dn0, bz0, ct0} !== {e_ph[0][2:0], e_idx[0][1:0], e_done[0], e_busy[0], e_cnt[0]} || ph0 !== want) begin
        n_fail++;
        $display("FAIL free_run edge %0d: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want ph=%b idx=%0d done=%b busy=%b cnt=%0d",
                 i + 1, ph0, ix0, dn0, bz0, ct0, want, e_idx[0], e_done[0], e_busy[0], e_cnt[0]);
      end
    end
    // Third cycle is on its last phase; the edge leaving it completes it.
    run_i = 1'b0;
    tick();
    n_tests++;
    if (ct0 !== 32'd3 || bz0 !== 1'b0 || ph0 !== 3'b000) begin
      n_fail++;
      $display("FAIL free_run_count: got cnt=%0d busy=%b ph=%b, want cnt=3 busy=0 ph=000", ct0, bz0, ph0);
    end
  endtask

  task automatic test_step();
    logic [31:0] base;
    int          busy_cycles;
    base        = ct0;
    busy_cycles = 0;
    run_i = 1'b0; step_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      // Second pulse lands while busy and must be ignored.
      step_i = (i == 1);
      if (bz0) busy_cycles++;
      n_tests++;
      if ({ph0, ix0, dn0, bz0, ct0} !== {e_ph[0][2:0], e_idx[0][1:0], e_done[0], e_busy[0], e_cnt[0]}) begin
        n_fail++;
        $display("FAIL step edge %0d: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want ph=%b idx=%0d done=%b busy=%b cnt=%0d",
                 i + 1, ph0, ix0, dn0, bz0, ct0, e_ph[0][2:0], e_idx[0], e_done[0], e_busy[0], e_cnt[0]);
      end
    end
    step_i = 1'b0;
    n_tests++;
    if (busy_cycles != 3 || ct0 !== base + 32'd1) begin
      n_fail++;
      $display("FAIL step_summary: got busy_cycles=%0d cnt=%0d, want busy_cycles=3 cnt=%0d", busy_cycles, ct0, base + 32'd1);
    end
  endtask

  task automatic test_wait();
    logic [2:0] want;
    run_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      wait_i = (i < 4) || (i == 5);
      if (i == 6) run_i = 1'b0;
      want = (i < 5) ? 3'b001 : (i == 5) ? 3'b010 : (i == 6) ? 3'b100 : 3'b000;
      n_tests++;
      if ({ph0, ix0, dn0, bz0, ct0} !== {e_ph[0][2:0], e_idx[0][1:0], e_done[0], e_busy[0], e_cnt[0]} || ph0 !== want) begin
        n_fail++;
        $display("FAIL wait edge %0d: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want ph=%b idx=%0d done=%b busy=%b cnt=%0d",
                 i + 1, ph0, ix0, dn0, bz0, ct0, want, e_idx[0], e_done[0], e_busy[0], e_cnt[0]);
      end
    end
    wait_i = 1'b0;
  endtask

  task automatic test_graceful_stop();
    logic [31:0] base;
    base  = ct0;
    run_i = 1'b1;
    tick();
    tick();
    run_i = 1'b0;
    tick();
    n_tests++;
    if (ph0 !== 3'b100 || bz0 !== 1'b1 || dn0 !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_last_phase: got ph=%b busy=%b done=%b, want ph=100 busy=1 done=1", ph0, bz0, dn0);
    end
    tick();
    n_tests++;
    if (ph0 !== 3'b000 || bz0 !== 1'b0 || ct0 !== base + 32'd1) begin
      n_fail++;
      $display("FAIL stop_idle: got ph=%b busy=%b cnt=%0d, want ph=000 busy=0 cnt=%0d", ph0, bz0, ct0, base + 32'd1);
    end
  endtask

  task automatic test_async_reset();
    run_i = 1'b1;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    model_expect();
    n_tests++;
    if ({ph0, ix0, dn0, bz0, ct0} !== 39'd0 || {ph1, ix1, dn1, bz1, ct1} !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset: got dut0 ph=%b busy=%b cnt=%0d dut1 ph=%b busy=%b cnt=%0d, want all zero", ph0, bz0, ct0, ph1, bz1, ct1);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) run_i = 1'b0;
      n_tests++;
      if ({ph0, ix0, dn0, bz0, ct0} !== {e_ph[0][2:0], e_idx[0][1:0], e_done[0], e_busy[0], e_cnt[0]}) begin
        n_fail++;
        $display("FAIL post_reset edge %0d: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want ph=%b idx=%0d done=%b busy=%b cnt=%0d",
                 i + 1, ph0, ix0, dn0, bz0, ct0, e_ph[0][2:0], e_idx[0], e_done[0], e_busy[0], e_cnt[0]);
      end
    end
  endtask

  task automatic test_params();
    logic [4:0] want;
    rst_n = 1'b0; run_i = 1'b0; step_i = 1'b0; wait_i = 1'b0;
    tick();
    rst_n = 1'b1;
    run_i = 1'b1;
    for (int i = 0; i < 85; i++) begin
      tick();
      want = 5'b00001 << (i % 5);
      n_tests++;
      if ({ph1, ix1, dn1, bz1, ct1} !== {e_ph[1][4:0], e_idx[1][2:0], e_done[1], e_busy[1], e_cnt[1][3:0]} || ph1 !== want) begin
        n_fail++;
        $display("FAIL five_phase edge %0d: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want ph=%b idx=%0d done=%b busy=%b cnt=%0d",
                 i + 1, ph1, ix1, dn1, bz1, ct1, want, e_idx[1], e_done[1], e_busy[1], e_cnt[1]);
      end
    end
    run_i = 1'b0;
    tick();
    n_tests++;
    if (ct1 !== 4'd1 || bz1 !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_count: got cnt=%0d busy=%b, want cnt=1 busy=0", ct1, bz1);
    end
    run_i = 1'b1;
    repeat (5) tick();
    wait_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ph1 !== 5'b10000 || dn1 !== 1'b1 || ct1 !== 4'd1 || ix1 !== 3'd4) begin
        n_fail++;
        $display("FAIL last_phase_stall %0d: got ph=%b idx=%0d done=%b cnt=%0d, want ph=10000 idx=4 done=1 cnt=1", i, ph1, ix1, dn1, ct1);
      end
    end
    wait_i = 1'b0;
    run_i  = 1'b0;
    tick();
    n_tests++;
    if (ph1 !== 5'b00000 || bz1 !== 1'b0 || ct1 !== 4'd2) begin
      n_fail++;
      $display("FAIL stall_release: got ph=%b busy=%b cnt=%0d, want ph=00000 busy=0 cnt=2", ph1, bz1, ct1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      run_i  = ($urandom_range(0, 99) < 45);
      step_i = ($urandom_range(0, 99) < 25);
      wait_i = ($urandom_range(0, 99) < 30);
      rst_n  = ($urandom_range(0, 63) != 0);
      tick();
      n_tests++;
      if ({ph0, ix0, dn0, bz0, ct0} !== {e_ph[0][2:0], e_idx[0][1:0], e_done[0], e_busy[0], e_cnt[0]}) begin
        n_fail++;
        $display("FAIL random_dut0 edge %0d: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want ph=%b idx=%0d done=%b busy=%b cnt=%0d",
                 i, ph0, ix0, dn0, bz0, ct0, e_ph[0][2:0], e_idx[0], e_done[0], e_busy[0], e_cnt[0]);
      end
      n_tests++;
      if ({ph1, ix1, dn1, bz1, ct1} !== {e_ph[1][4:0], e_idx[1][2:0], e_done[1], e_busy[1], e_cnt[1][3:0]}) begin
        n_fail++;
        $display("FAIL random_dut1 edge %0d: got ph=%b idx=%0d done=%b busy=%b cnt=%0d, want ph=%b idx=%0d done=%b busy=%b cnt=%0d",
                 i, ph1, ix1, dn1, bz1, ct1, e_ph[1][4:0], e_idx[1], e_done[1], e_busy[1], e_cnt[1]);
      end
    end
    rst_n = 1'b1; run_i = 1'b0; step_i = 1'b0; wait_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run_i = 1'b0; step_i = 1'b0; wait_i = 1'b0;
    model_clear();
    model_expect();
    test_reset();
    test_free_run();
    test_step();
    test_wait();
    test_graceful_stop();
    test_async_reset();
    test_params();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
